// File: rtl/sigmoid_sym_pipe_if.sv
// Valid/ready stream bundle for the sigmoid pipeline: one input channel, one output channel.
// slave is the pipeline side; master is the producer/consumer side.
interface sigmoid_sym_pipe_if #(
    parameter int DATA_W = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sigmoid_sym_pipe.sv
// Three-stage piecewise-linear sigmoid built on sigmoid(-x) = 1 - sigmoid(x):
// fold to |x|, evaluate shift-and-add segments, then unfold negative inputs.
module sigmoid_sym_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sigmoid_sym_pipe_if.slave    bus
);
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1)  << FRAC_W;
    localparam logic [DATA_W-1:0] T_SAT   = DATA_W'(5)  << FRAC_W;        // 5.0
    localparam logic [DATA_W-1:0] T_HI    = DATA_W'(19) << (FRAC_W - 3);  // 2.375
    localparam logic [DATA_W-1:0] OFF_HI  = DATA_W'(27) << (FRAC_W - 5);  // 0.84375
    localparam logic [DATA_W-1:0] OFF_MID = DATA_W'(5)  << (FRAC_W - 3);  // 0.625
    localparam logic [DATA_W-1:0] OFF_LO  = DATA_W'(1)  << (FRAC_W - 1);  // 0.5
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic              s1_valid, s1_sgn;
    logic [DATA_W-1:0] s1_a;
    logic              s2_valid, s2_sgn;
    logic [DATA_W-1:0] s2_y;
    logic              s3_valid;
    logic [DATA_W-1:0] s3_data;

    logic              adv;
    logic              fold_sgn;
    logic [DATA_W-1:0] fold_a;
    logic [DATA_W-1:0] seg_y;
    logic [DATA_W-1:0] unfold_y;

    // All stages move in lockstep; a full output register only advances when drained.
    assign adv           = ~s3_valid | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = s3_valid;
    assign bus.out_data  = s3_data;

    // NOTE: combinational blocks assign every output first so no path can infer a latch.
    always_comb begin
        fold_sgn = bus.in_data[DATA_W-1];
        fold_a   = bus.in_data;
        if (fold_sgn) begin
            // Negating the most negative value would overflow back to itself.
            fold_a = (bus.in_data == MIN_NEG) ? MAX_POS : (~bus.in_data + DATA_W'(1));
        end
    end

    always_comb begin
        seg_y = (s1_a >> 2) + OFF_LO;
        if (s1_a >= T_SAT) begin
            seg_y = ONE;
        end else if (s1_a >= T_HI) begin
            seg_y = (s1_a >> 5) + OFF_HI;
        end else if (s1_a >= ONE) begin
            seg_y = (s1_a >> 3) + OFF_MID;
        end
    end

    // ONE - y in two's complement; y never exceeds ONE so the result stays in [0, ONE].
    assign unfold_y = s2_sgn ? (~s2_y + ONE + DATA_W'(1)) : s2_y;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the previous stage's pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sgn   <= 1'b0;
            s1_a     <= '0;
            s2_valid <= 1'b0;
            s2_sgn   <= 1'b0;
            s2_y     <= '0;
            s3_valid <= 1'b0;
            s3_data  <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_sgn   <= fold_sgn;
            s1_a     <= fold_a;
            s2_valid <= s1_valid;
            s2_sgn   <= s1_sgn;
            s2_y     <= seg_y;
            s3_valid <= s2_valid;
            s3_data  <= unfold_y;
        end
    end
endmodule

// File: tb/tb_sigmoid_sym_pipe.sv
// Randomized and directed bench for sigmoid_sym_pipe: an integer sigmoid model feeds a
// queue scoreboard, with latency, hold, in_ready and reset behaviour checked alongside.
module tb_sigmoid_sym_pipe;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_q[$];
    logic prev_stall;
    int   prev_data;

    sigmoid_sym_pipe_if #(.DATA_W(DATA_W)) bus ();

    sigmoid_sym_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sigmoid approximation in real-number terms, scaled by 256 (Q8.8).
    function automatic int sig_ref(input int raw);
        int x, a, y;
        x = (raw & 16'hFFFF) >= 32768 ? (raw & 16'hFFFF) - 65536 : (raw & 16'hFFFF);
        a = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        if (a >= 5 * 256)        y = 256;
        else if (a >= 608)       y = a / 32 + 216;
        else if (a >= 256)       y = a / 8 + 160;
        else                     y = a / 4 + 128;
        return (x < 0) ? 256 - y : y;
    endfunction

    // Monitor: samples at the falling edge what the next rising edge will commit.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(bus.out_valid), 1);
                check("hold_data", int'(bus.out_data), prev_data);
            end
            check("in_ready_adv", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else check("sb_data", int'(bus.out_data), exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(sig_ref(int'(bus.in_data)));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = int'(bus.out_data);
        end
    end

    function automatic logic [DATA_W-1:0] rand_x();
        if ($urandom_range(0, 3) == 0) return DATA_W'($urandom);
        return DATA_W'(int'($urandom_range(0, 3072)) - 1536);
    endfunction

    task automatic single(input logic [DATA_W-1:0] x, input int exp, input string tag);
        int n;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = x;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, 3);
        check(tag, int'(bus.out_data), exp);
    endtask

    initial begin
        logic [DATA_W-1:0] dir_x[13];
        int                dir_y[13];
        int                first, last, cnt, acc, cyc;

        n_checks = 0;
        n_fail   = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // 1: reset with valid input presented
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0100;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("post_rst_quiet", int'(bus.out_valid), 0);
        end

        // 2 + 3: directed values and segment boundaries
        dir_x = '{16'h0000, 16'h0080, 16'h0100, 16'hFF00, 16'h0300, 16'h0600, 16'hF800,
                  16'h025F, 16'h0260, 16'h04FF, 16'h0500, 16'h8000, 16'h7FFF};
        dir_y = '{'h80, 'hA0, 'hC0, 'h40, 'hF0, 'h100, 'h0,
                  'hEB, 'hEB, 'hFF, 'h100, 'h0, 'h100};
        for (int i = 0; i < 13; i++) single(dir_x[i], dir_y[i], $sformatf("dir_%0h", dir_x[i]));

        // 4: 16 back-to-back samples
        @(posedge clk); #1;
        first = -1; last = -1; cnt = 0;
        for (int i = 0; i < 24; i++) begin
            bus.in_valid = (i < 16);
            bus.in_data  = rand_x();
            @(posedge clk); #1;
            if (bus.out_valid) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
        end
        check("b2b_count", cnt, 16);
        check("b2b_span", last - first + 1, 16);
        check("b2b_first", first, 2);

        // 5: random backpressure over 1000 accepted samples
        acc = 0; cyc = 0;
        while (acc < 1000 && cyc < 6000) begin
            @(posedge clk); #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = rand_x();
            bus.out_ready = $urandom_range(0, 1);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            cyc++;
        end
        check("bp_accepted", acc, 1000);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_drained", exp_q.size(), 0);

        // 6: async reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rand_x();
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        check("inflight_valid", int'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", int'(bus.out_valid), 0);
        check("async_out_data", int'(bus.out_data), 0);
        check("async_in_ready", int'(bus.in_ready), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        single(16'h0100, 'hC0, "after_rst");
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
